// File: rtl/demux12_buf_if.sv
// Stream bundle for demux12_buf: one valid/ready input, two valid/ready outputs
// with per-port delivery counters.
interface demux12_buf_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
);
    logic             S1;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic             DR;
    logic [WIDTH-1:0] Y0;
    logic             Y0V;
    logic             Y0R;
    logic [WIDTH-1:0] Y1;
    logic             Y1V;
    logic             Y1R;
    logic [CW-1:0]    CNT0;
    logic [CW-1:0]    CNT1;

    // master: producer plus both consumers; slave: the demux itself
    modport master (
        output S1, D, DV, Y0R, Y1R,
        input  DR, Y0, Y0V, Y1, Y1V, CNT0, CNT1
    );

    modport slave (
        input  S1, D, DV, Y0R, Y1R,
        output DR, Y0, Y0V, Y1, Y1V, CNT0, CNT1
    );
endinterface

// File: rtl/demux12_buf.sv
// Buffered 1-to-2 demux: each accepted word is steered by S1 into one of two
// independent 2-entry FIFOs, so a stalled consumer never blocks the other port.
module demux12_buf_port #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             vld_o,
    output logic             full_o,
    output logic [CW-1:0]    cnt_o
);
    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            occ_q, occ_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        occ_d  = occ_q;
        if (push_i) begin
            mem_d[wptr_q] = din_i;
            wptr_d        = ~wptr_q;
        end
        if (pop_i) begin
            rptr_d = ~rptr_q;
            cnt_d  = cnt_q + CW'(1);
        end
        // push+pop together leaves occupancy unchanged
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ_q  <= 2'd0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o = mem_q[rptr_q];
    assign vld_o  = (occ_q != 2'd0);
    assign full_o = (occ_q == 2'd2);
    assign cnt_o  = cnt_q;
endmodule

module demux12_buf #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
) (
    input  logic          CLK,
    input  logic          RST,
    demux12_buf_if.slave  bus
);
    logic [1:0]            push, pop, vld, full, rdy;
    logic [1:0][WIDTH-1:0] dout;
    logic [1:0][CW-1:0]    cnt;
    logic                  dr;

    // ready looks only at the selected FIFO, never at the consumers' ready
    assign dr     = ~full[bus.S1];
    assign bus.DR = dr;
    assign rdy    = {bus.Y1R, bus.Y0R};
    assign pop    = vld & rdy;

    for (genvar n = 0; n < 2; n++) begin : g_port
        assign push[n] = bus.DV & dr & (bus.S1 == 1'(n));

        demux12_buf_port #(.WIDTH(WIDTH), .CW(CW)) u_port (
            .CLK    (CLK),
            .RST    (RST),
            .push_i (push[n]),
            .din_i  (bus.D),
            .pop_i  (pop[n]),
            .dout_o (dout[n]),
            .vld_o  (vld[n]),
            .full_o (full[n]),
            .cnt_o  (cnt[n])
        );
    end

    assign bus.Y0   = dout[0];
    assign bus.Y1   = dout[1];
    assign bus.Y0V  = vld[0];
    assign bus.Y1V  = vld[1];
    assign bus.CNT0 = cnt[0];
    assign bus.CNT1 = cnt[1];
endmodule
